// File: rtl/l6_ctrl_pkg.sv
// Shared constants and types for the lab-6 multi-cycle control unit.
package l6_ctrl_pkg;

   localparam logic [3:0] OP_ADD  = 4'h0;
   localparam logic [3:0] OP_SUB  = 4'h1;
   localparam logic [3:0] OP_AND  = 4'h2;
   localparam logic [3:0] OP_OR   = 4'h3;
   localparam logic [3:0] OP_ADDI = 4'h4;
   localparam logic [3:0] OP_LD   = 4'h8;
   localparam logic [3:0] OP_ST   = 4'h9;
   localparam logic [3:0] OP_BZ   = 4'hA;
   localparam logic [3:0] OP_BNZ  = 4'hB;
   localparam logic [3:0] OP_JMP  = 4'hC;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [1:0] PC_INC    = 2'd0;
   localparam logic [1:0] PC_BRANCH = 2'd1;
   localparam logic [1:0] PC_JUMP   = 2'd2;

   localparam logic [1:0] ALU_ADD = 2'd0;
   localparam logic [1:0] ALU_SUB = 2'd1;
   localparam logic [1:0] ALU_AND = 2'd2;
   localparam logic [1:0] ALU_OR  = 2'd3;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_BRANCH,
      S_HALTED
   } state_e;

   typedef struct packed {
      logic is_rtype;
      logic is_addi;
      logic is_ld;
      logic is_st;
      logic is_bz;
      logic is_bnz;
      logic is_jmp;
      logic is_halt;
      logic is_illegal;
   } op_class_t;

endpackage

// File: rtl/l6_ctrl_decode.sv
// Combinational opcode classifier; exactly one class flag is set for any opcode.
module l6_ctrl_decode
   import l6_ctrl_pkg::*;
(
   input  logic [3:0] opcode_i,
   output op_class_t  cls_o
);

   always_comb begin
      cls_o = '0;
      case (opcode_i)
         OP_ADD, OP_SUB, OP_AND, OP_OR: cls_o.is_rtype = 1'b1;
         OP_ADDI: cls_o.is_addi   = 1'b1;
         OP_LD:   cls_o.is_ld     = 1'b1;
         OP_ST:   cls_o.is_st     = 1'b1;
         OP_BZ:   cls_o.is_bz     = 1'b1;
         OP_BNZ:  cls_o.is_bnz    = 1'b1;
         OP_JMP:  cls_o.is_jmp    = 1'b1;
         OP_HALT: cls_o.is_halt   = 1'b1;
         default: cls_o.is_illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/l6_mc_control.sv
// Multi-cycle FSM sequencing the lab-6 CPU datapath, with a memory-wait
// watchdog and a retired-instruction counter.
module l6_mc_control
   import l6_ctrl_pkg::*;
#(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 255
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic [15:0]      instr,
   input  logic             mem_ready,
   input  logic             branch,
   output logic             mem_req,
   output logic             mem_we,
   output logic             mem_addr_sel,
   output logic             ir_write,
   output logic             pc_write,
   output logic [1:0]       pc_src,
   output logic [1:0]       alu_op,
   output logic             alu_src,
   output logic             rf_we,
   output logic             rf_wsel,
   output logic             bz,
   output logic             bnz,
   output logic             retired,
   output logic             illegal,
   output logic             halted,
   output logic             mem_err,
   output logic [CNT_W-1:0] instr_count
);

   localparam int WAIT_W = 10;

   state_e              state_q, state_d;
   logic [WAIT_W-1:0]   wait_q, wait_d;
   logic                err_q, err_d;
   logic [CNT_W-1:0]    count_q;
   op_class_t           cls;
   logic                memAccess;
   logic                waiting;
   logic                timeout;
   logic                unused_instr_bits;

   assign unused_instr_bits = ^instr[11:0];

   l6_ctrl_decode u_decode (
      .opcode_i (instr[15:12]),
      .cls_o    (cls)
   );

   // Outputs are decodes of the state register, so reset gates them off combinationally.
   assign memAccess = rst_n && (state_q == S_FETCH || state_q == S_MEM);
   assign waiting   = memAccess && !mem_ready;
   assign timeout   = waiting && (wait_q == WAIT_W'(MEM_TIMEOUT - 1));
   assign wait_d    = waiting ? wait_q + 1'b1 : '0;

   always_comb begin
      state_d      = state_q;
      err_d        = err_q;
      mem_req      = memAccess;
      mem_we       = 1'b0;
      mem_addr_sel = 1'b0;
      ir_write     = 1'b0;
      pc_write     = 1'b0;
      pc_src       = PC_INC;
      alu_op       = ALU_ADD;
      alu_src      = 1'b0;
      rf_we        = 1'b0;
      rf_wsel      = 1'b0;
      bz           = 1'b0;
      bnz          = 1'b0;
      retired      = 1'b0;
      illegal      = 1'b0;
      halted       = 1'b0;
      if (rst_n) begin
         case (state_q)
            S_FETCH: begin
               if (mem_ready) begin
                  ir_write = 1'b1;
                  pc_write = 1'b1;
                  state_d  = S_DECODE;
               end else if (timeout) begin
                  err_d   = 1'b1;
                  state_d = S_HALTED;
               end
            end
            S_DECODE: begin
               if (cls.is_rtype || cls.is_addi || cls.is_ld || cls.is_st) begin
                  state_d = S_EXEC;
               end else if (cls.is_bz || cls.is_bnz) begin
                  state_d = S_BRANCH;
               end else if (cls.is_jmp) begin
                  pc_write = 1'b1;
                  pc_src   = PC_JUMP;
                  retired  = 1'b1;
                  state_d  = S_FETCH;
               end else if (cls.is_halt) begin
                  retired = 1'b1;
                  state_d = S_HALTED;
               end else begin
                  illegal = 1'b1;
                  retired = 1'b1;
                  state_d = S_FETCH;
               end
            end
            S_EXEC: begin
               alu_src = !cls.is_rtype;
               alu_op  = cls.is_rtype ? instr[13:12] : ALU_ADD;
               state_d = (cls.is_ld || cls.is_st) ? S_MEM : S_WB;
            end
            S_MEM: begin
               mem_addr_sel = 1'b1;
               mem_we       = cls.is_st;
               if (mem_ready) begin
                  retired = cls.is_st;
                  state_d = cls.is_st ? S_FETCH : S_WB;
               end else if (timeout) begin
                  err_d   = 1'b1;
                  state_d = S_HALTED;
               end
            end
            S_WB: begin
               rf_we   = 1'b1;
               rf_wsel = cls.is_ld;
               retired = 1'b1;
               state_d = S_FETCH;
            end
            S_BRANCH: begin
               bz      = cls.is_bz;
               bnz     = cls.is_bnz;
               retired = 1'b1;
               if (branch) begin
                  pc_write = 1'b1;
                  pc_src   = PC_BRANCH;
               end
               state_d = S_FETCH;
            end
            S_HALTED: halted = 1'b1;
            default:  state_d = S_FETCH;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
         err_q   <= 1'b0;
         count_q <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
         err_q   <= err_d;
         if (retired) begin
            count_q <= count_q + CNT_W'(1);
         end
      end
   end

   assign mem_err     = err_q;
   assign instr_count = count_q;

endmodule

// File: tb/tb_l6_mc_control.sv
// Randomized scoreboard bench for l6_mc_control: a phase-level model pushes
// per-cycle expectations, a negedge monitor pops and compares them.
module tb_l6_mc_control;

   localparam int CNT_W = 4;
   localparam int TMO   = 4;

   logic             clock = 1'b0;
   logic             rstN;
   logic [15:0]      instrIn;
   logic             memReady;
   logic             branchIn;
   logic             memReq, memWe, memAddrSel, irWrite, pcWrite;
   logic [1:0]       pcSrc, aluOp;
   logic             aluSrc, rfWe, rfWsel, bzOut, bnzOut;
   logic             retiredOut, illegalOut, haltedOut, memErr;
   logic [CNT_W-1:0] instrCount;

   typedef struct packed {
      logic       req, sel, we, irW, pcW;
      logic [1:0] pcSrc, aluOp;
      logic       aluSrc, rfWe, rfWsel, bz, bnz, ret, ill, halted, err;
      logic [3:0] cnt;
      logic       chkRegs;
   } exp_t;

   exp_t        cycleQ[$];
   int          compared   = 0;
   int          mismatched = 0;
   int          cyc        = 0;
   int          modelCnt   = 0;
   logic        modelErr   = 1'b0;
   logic        modelHalted = 1'b0;
   logic        curRst     = 1'b0;
   logic [15:0] curInstr   = 16'h0;

   l6_mc_control #(.CNT_W(CNT_W), .MEM_TIMEOUT(TMO)) dut (
      .clk          (clock),
      .rst_n        (rstN),
      .instr        (instrIn),
      .mem_ready    (memReady),
      .branch       (branchIn),
      .mem_req      (memReq),
      .mem_we       (memWe),
      .mem_addr_sel (memAddrSel),
      .ir_write     (irWrite),
      .pc_write     (pcWrite),
      .pc_src       (pcSrc),
      .alu_op       (aluOp),
      .alu_src      (aluSrc),
      .rf_we        (rfWe),
      .rf_wsel      (rfWsel),
      .bz           (bzOut),
      .bnz          (bnzOut),
      .retired      (retiredOut),
      .illegal      (illegalOut),
      .halted       (haltedOut),
      .mem_err      (memErr),
      .instr_count  (instrCount)
   );

   always #5 clock = ~clock;

   function automatic logic rb();
      return 1'($urandom_range(0, 1));
   endfunction

   function automatic exp_t base();
      exp_t e;
      e         = '0;
      e.cnt     = 4'(modelCnt % 16);
      e.err     = modelErr;
      e.halted  = modelHalted;
      e.chkRegs = 1'b1;
      return e;
   endfunction

   task automatic checkOutput(input string nm, input logic [7:0] act, input logic [7:0] exp);
      compared++;
      if (act !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s cycle=%0d got=%0h expected=%0h", nm, cyc, act, exp);
      end
   endtask

   // One clock of stimulus: drive inputs just after the edge and queue what the DUT must show.
   task automatic applyStimulus(input exp_t e, input logic rdy, input logic br);
      @(posedge clock);
      #1;
      rstN     = curRst;
      instrIn  = curInstr;
      memReady = rdy;
      branchIn = br;
      cycleQ.push_back(e);
   endtask

   task automatic doReset(input int n);
      exp_t e;
      curRst      = 1'b0;
      modelCnt    = 0;
      modelErr    = 1'b0;
      modelHalted = 1'b0;
      for (int i = 0; i < n; i++) begin
         e         = base();
         e.chkRegs = (i > 0);
         applyStimulus(e, rb(), rb());
      end
      curRst = 1'b1;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(base(), rb(), rb());
   endtask

   task automatic fetchPhase(input int wf);
      exp_t e;
      for (int i = 0; i < wf; i++) begin
         e = base(); e.req = 1'b1;
         applyStimulus(e, 1'b0, rb());
      end
      e = base(); e.req = 1'b1; e.irW = 1'b1; e.pcW = 1'b1;
      applyStimulus(e, 1'b1, rb());
   endtask

   // Instruction-level reference: each class is a fixed list of phases plus memory waits.
   task automatic runInstr(input logic [15:0] ins, input int wf, input int wm);
      exp_t       e;
      logic [3:0] op;
      logic       br;
      op       = ins[15:12];
      curInstr = ins;
      fetchPhase(wf);
      e = base();
      if (op == 4'hC) begin
         e.pcW = 1'b1; e.pcSrc = 2'd2; e.ret = 1'b1;
         applyStimulus(e, rb(), rb()); modelCnt++; return;
      end
      if (op == 4'hF) begin
         e.ret = 1'b1;
         applyStimulus(e, rb(), rb()); modelCnt++; modelHalted = 1'b1; return;
      end
      if (op inside {4'h5, 4'h6, 4'h7, 4'hD, 4'hE}) begin
         e.ill = 1'b1; e.ret = 1'b1;
         applyStimulus(e, rb(), rb()); modelCnt++; return;
      end
      applyStimulus(e, rb(), rb());
      if (op == 4'hA || op == 4'hB) begin
         e = base(); br = rb();
         e.bz = (op == 4'hA); e.bnz = (op == 4'hB);
         e.pcW = br; e.pcSrc = br ? 2'd1 : 2'd0; e.ret = 1'b1;
         applyStimulus(e, rb(), br); modelCnt++; return;
      end
      e = base(); e.aluSrc = (op >= 4'h4); e.aluOp = (op < 4'h4) ? op[1:0] : 2'd0;
      applyStimulus(e, rb(), rb());
      if (op == 4'h8 || op == 4'h9) begin
         for (int i = 0; i < wm; i++) begin
            e = base(); e.req = 1'b1; e.sel = 1'b1; e.we = (op == 4'h9);
            applyStimulus(e, 1'b0, rb());
         end
         e = base(); e.req = 1'b1; e.sel = 1'b1; e.we = (op == 4'h9); e.ret = (op == 4'h9);
         applyStimulus(e, 1'b1, rb());
         if (op == 4'h9) begin modelCnt++; return; end
      end
      e = base(); e.rfWe = 1'b1; e.rfWsel = (op == 4'h8); e.ret = 1'b1;
      applyStimulus(e, rb(), rb()); modelCnt++;
   endtask

   // Memory never answers: TMO request cycles, then the core halts with the error flag.
   task automatic runTimeout(input logic inMem);
      exp_t e;
      curInstr = 16'h8123;
      if (inMem) begin
         fetchPhase(0);
         applyStimulus(base(), rb(), rb());
         e = base(); e.aluSrc = 1'b1;
         applyStimulus(e, rb(), rb());
      end
      for (int i = 0; i < TMO; i++) begin
         e = base(); e.req = 1'b1; e.sel = inMem;
         applyStimulus(e, 1'b0, rb());
      end
      modelErr    = 1'b1;
      modelHalted = 1'b1;
   endtask

   // Store abandoned by reset while waiting in its memory phase.
   task automatic stAbort();
      exp_t e;
      curInstr = 16'h9abc;
      fetchPhase(0);
      applyStimulus(base(), rb(), rb());
      e = base(); e.aluSrc = 1'b1;
      applyStimulus(e, rb(), rb());
      e = base(); e.req = 1'b1; e.sel = 1'b1; e.we = 1'b1;
      applyStimulus(e, 1'b0, rb());
      doReset(1);
   endtask

   always @(negedge clock) begin
      exp_t e;
      if (cycleQ.size() != 0) begin
         e = cycleQ.pop_front();
         cyc++;
         checkOutput("mem_req", 8'(memReq), 8'(e.req));
         checkOutput("mem_addr_sel", 8'(memAddrSel), 8'(e.sel));
         checkOutput("mem_we", 8'(memWe), 8'(e.we));
         checkOutput("ir_write", 8'(irWrite), 8'(e.irW));
         checkOutput("pc_write", 8'(pcWrite), 8'(e.pcW));
         checkOutput("pc_src", 8'(pcSrc), 8'(e.pcSrc));
         checkOutput("alu_op", 8'(aluOp), 8'(e.aluOp));
         checkOutput("alu_src", 8'(aluSrc), 8'(e.aluSrc));
         checkOutput("rf_we", 8'(rfWe), 8'(e.rfWe));
         checkOutput("rf_wsel", 8'(rfWsel), 8'(e.rfWsel));
         checkOutput("bz", 8'(bzOut), 8'(e.bz));
         checkOutput("bnz", 8'(bnzOut), 8'(e.bnz));
         checkOutput("retired", 8'(retiredOut), 8'(e.ret));
         checkOutput("illegal", 8'(illegalOut), 8'(e.ill));
         if (e.chkRegs) begin
            checkOutput("halted", 8'(haltedOut), 8'(e.halted));
            checkOutput("mem_err", 8'(memErr), 8'(e.err));
            checkOutput("instr_count", 8'(instrCount), 8'(e.cnt));
         end
      end
   end

   initial begin
      logic [3:0] op;
      rstN     = 1'b0;
      instrIn  = 16'h0;
      memReady = 1'b0;
      branchIn = 1'b0;
      doReset(2);
      runInstr(16'h0123, 0, 0);
      runInstr(16'h8456, 0, 3);
      runInstr(16'hA010, 1, 0);
      runInstr(16'hB020, 0, 0);
      runInstr(16'h5000, 0, 0);
      for (int i = 0; i < 150; i++) begin
         op = 4'($urandom_range(0, 14));
         runInstr({op, 12'($urandom)}, $urandom_range(0, TMO - 1), $urandom_range(0, TMO - 1));
      end
      runInstr(16'hF000, 2, 0);
      idle(6);
      doReset(2);
      runInstr(16'h4001, 0, 0);
      runInstr(16'hC000, 3, 0);
      stAbort();
      runInstr(16'h0123, 0, 0);
      runTimeout(1'b0);
      idle(4);
      doReset(2);
      runTimeout(1'b1);
      idle(4);
      doReset(2);
      runInstr(16'h9001, 0, TMO - 1);
      runInstr(16'h0321, 0, 0);
      @(negedge clock);
      #1;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
